// File: rtl/jolt80_alu_pkg.sv
// jolt80_alu_pkg: ALU opcode enum, datapath widths and processor-flag bit positions.
package pkg_alu;
    localparam int REG_W = 8;
    localparam int PAIR_W = 2 * REG_W;
    localparam int OP_W = 5;
    typedef enum logic [OP_W-1:0] {
        op_add8 = 5'd0, op_adc8 = 5'd1, op_sub8 = 5'd2, op_sbc8 = 5'd3, op_cmp8 = 5'd4,
        op_and8 = 5'd5, op_orr8 = 5'd6, op_xor8 = 5'd7,
        op_lsl8 = 5'd8, op_lsr8 = 5'd9, op_asr8 = 5'd10, op_rol8 = 5'd11, op_ror8 = 5'd12,
        op_not8 = 5'd13, op_cpy8 = 5'd14,
        op_add16 = 5'd15, op_sub16 = 5'd16, op_addsi16 = 5'd17, op_cpy16 = 5'd18
    } alu_op_e;
endpackage

package pkg_pflags;
    localparam int PFLAG_W = 4;
    localparam int pflag_c = 0;
    localparam int pflag_v = 1;
    localparam int pflag_n = 2;
    localparam int pflag_z = 3;
endpackage

// File: rtl/jolt80_alu_if.sv
// jolt80_alu_if: operand/result bundle between the register file side and the ALU stage.
interface jolt80_alu_if;
    import pkg_alu::*;
    import pkg_pflags::*;
    logic in_valid;
    logic [OP_W-1:0] oper;
    logic [REG_W-1:0] a_in_hi, a_in_lo, b_in_hi, b_in_lo;
    logic [PFLAG_W-1:0] proc_flags_in;
    logic out_valid;
    logic [REG_W-1:0] out_hi, out_lo;
    logic [PFLAG_W-1:0] proc_flags_out;
    modport master(output in_valid, oper, a_in_hi, a_in_lo, b_in_hi, b_in_lo, proc_flags_in,
                   input out_valid, out_hi, out_lo, proc_flags_out);
    modport slave(input in_valid, oper, a_in_hi, a_in_lo, b_in_hi, b_in_lo, proc_flags_in,
                  output out_valid, out_hi, out_lo, proc_flags_out);
endinterface

// File: rtl/jolt80_alu_addsub.sv
// alu_addsub_core: shared 8/16-bit adder; subtraction is a + ~b + cin so carry means "no borrow".
module alu_addsub_core
    import pkg_alu::*;
(
    input  logic [PAIR_W-1:0] a,
    input  logic [PAIR_W-1:0] b,
    input  logic              cin,
    input  logic              sub,
    input  logic              w16,
    output logic [PAIR_W-1:0] res,
    output logic              c,
    output logic              v
);
    logic [PAIR_W-1:0] bx;
    logic [PAIR_W:0] s16;
    logic [REG_W:0] s8;
    assign bx = sub ? ~b : b;
    assign s16 = {1'b0, a} + {1'b0, bx} + {{PAIR_W{1'b0}}, cin};
    assign s8 = {1'b0, a[REG_W-1:0]} + {1'b0, bx[REG_W-1:0]} + {{REG_W{1'b0}}, cin};
    assign res = w16 ? s16[PAIR_W-1:0] : {{REG_W{1'b0}}, s8[REG_W-1:0]};
    assign c = w16 ? s16[PAIR_W] : s8[REG_W];
    assign v = w16 ? (a[PAIR_W-1] == bx[PAIR_W-1]) && (s16[PAIR_W-1] != a[PAIR_W-1])
                   : (a[REG_W-1] == bx[REG_W-1]) && (s8[REG_W-1] != a[REG_W-1]);
endmodule

// File: rtl/jolt80_alu.sv
// jolt80_alu: one-cycle registered ALU stage producing a result pair and updated C/V/N/Z flags.
module jolt80_alu
    import pkg_alu::*;
    import pkg_pflags::*;
(
    input logic clk,
    input logic reset,
    jolt80_alu_if.slave bus
);
    alu_op_e op;
    logic [PAIR_W-1:0] a, b, b_core, as_r, r;
    logic [PFLAG_W-1:0] f_in, f;
    logic [REG_W-1:0] lg, sh;
    logic [2:0] amt;
    logic [PAIR_W-1:0] lsl_t, lsr_t, asr_t, rol_t, ror_t;
    logic as_c, as_v, cin, sub, w16, sh_c;
    assign op = alu_op_e'(bus.oper);
    assign a = {bus.a_in_hi, bus.a_in_lo};
    assign b = {bus.b_in_hi, bus.b_in_lo};
    assign f_in = bus.proc_flags_in;
    assign amt = bus.b_in_lo[2:0];
    assign b_core = (op == op_addsi16) ? {{REG_W{bus.b_in_lo[REG_W-1]}}, bus.b_in_lo} : b;
    assign sub = op == op_sub8 || op == op_sbc8 || op == op_cmp8 || op == op_sub16;
    assign w16 = op == op_add16 || op == op_sub16 || op == op_addsi16;
    assign cin = (op == op_adc8 || op == op_sbc8) ? f_in[pflag_c]
               : (op == op_sub8 || op == op_cmp8 || op == op_sub16);
    alu_addsub_core u_core (
        .a(a), .b(b_core), .cin(cin), .sub(sub), .w16(w16), .res(as_r), .c(as_c), .v(as_v)
    );
    assign lg = op == op_and8 ? bus.a_in_lo & bus.b_in_lo
              : op == op_orr8 ? bus.a_in_lo | bus.b_in_lo
              : op == op_xor8 ? bus.a_in_lo ^ bus.b_in_lo : ~bus.a_in_lo;
    // Shifts run in a double-width window so the last bit out lands at a fixed position.
    assign lsl_t = {{REG_W{1'b0}}, bus.a_in_lo} << amt;
    assign lsr_t = {bus.a_in_lo, {REG_W{1'b0}}} >> amt;
    assign asr_t = $signed({bus.a_in_lo, {REG_W{1'b0}}}) >>> amt;
    assign rol_t = {bus.a_in_lo, bus.a_in_lo} << amt;
    assign ror_t = {bus.a_in_lo, bus.a_in_lo} >> amt;
    assign sh = op == op_lsl8 ? lsl_t[REG_W-1:0] : op == op_lsr8 ? lsr_t[PAIR_W-1:REG_W]
              : op == op_asr8 ? asr_t[PAIR_W-1:REG_W] : op == op_rol8 ? rol_t[PAIR_W-1:REG_W]
              : ror_t[REG_W-1:0];
    assign sh_c = op == op_lsl8 ? lsl_t[REG_W] : op == op_lsr8 ? lsr_t[REG_W-1]
                : op == op_asr8 ? asr_t[REG_W-1] : op == op_rol8 ? rol_t[REG_W]
                : ror_t[REG_W-1];
    always_comb begin
        r = '0;
        f = f_in;
        case (op)
            op_add8, op_adc8, op_sub8, op_sbc8, op_cmp8: begin
                r = (op == op_cmp8) ? {{REG_W{1'b0}}, bus.a_in_lo} : as_r;
                f[pflag_c] = as_c;
                f[pflag_v] = as_v;
                f[pflag_z] = as_r[REG_W-1:0] == '0;
                f[pflag_n] = as_r[REG_W-1];
            end
            op_and8, op_orr8, op_xor8, op_not8: begin
                r = {{REG_W{1'b0}}, lg};
                f[pflag_z] = lg == '0;
                f[pflag_n] = lg[REG_W-1];
            end
            op_lsl8, op_lsr8, op_asr8, op_rol8, op_ror8: begin
                r = {{REG_W{1'b0}}, sh};
                f[pflag_z] = sh == '0;
                f[pflag_n] = sh[REG_W-1];
                f[pflag_c] = (amt != 3'd0) ? sh_c : f_in[pflag_c];
            end
            op_cpy8: r = {{REG_W{1'b0}}, bus.b_in_lo};
            op_add16, op_sub16, op_addsi16: begin
                r = as_r;
                f[pflag_c] = as_c;
                f[pflag_v] = as_v;
                f[pflag_z] = as_r == '0;
                f[pflag_n] = as_r[PAIR_W-1];
            end
            op_cpy16: r = b;
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.out_valid <= 1'b0;
            bus.out_hi <= '0;
            bus.out_lo <= '0;
            bus.proc_flags_out <= '0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                {bus.out_hi, bus.out_lo} <= r;
                bus.proc_flags_out <= f;
            end
        end
    end
endmodule

// File: tb/tb_jolt80_alu.sv
// tb_jolt80_alu: directed vectors with hand-computed results; flags shown as {Z,N,V,C}.
module tb_jolt80_alu;
    typedef struct packed {
        logic [4:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  fi;
        logic [15:0] r;
        logic [3:0]  fo;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;

    jolt80_alu_if bus();
    jolt80_alu dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic drive(input vec_t v);
        bus.in_valid = 1'b1;
        bus.oper = v.op;
        {bus.a_in_hi, bus.a_in_lo} = v.a;
        {bus.b_in_hi, bus.b_in_lo} = v.b;
        bus.proc_flags_in = v.fi;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive({5'd0, 16'h00FF, 16'h0001, 4'b1111, 16'h0, 4'b0});
        step();
        step();
        checks++;
        if ({bus.out_valid, bus.out_hi, bus.out_lo, bus.proc_flags_out} !== 21'h0) begin
            errors++;
            $display("FAIL reset_hold got v=%b r=%h%h f=%b exp v=0 r=0000 f=0000",
                     bus.out_valid, bus.out_hi, bus.out_lo, bus.proc_flags_out);
        end
        reset = 1'b1;
        drive({5'd0, 16'h0001, 16'h0001, 4'b0000, 16'h0, 4'b0});
        step();
        checks++;
        if ({bus.out_valid, bus.out_hi, bus.out_lo, bus.proc_flags_out} !== {1'b1, 16'h0002, 4'b0000}) begin
            errors++;
            $display("FAIL reset_release got v=%b r=%h%h f=%b exp v=1 r=0002 f=0000",
                     bus.out_valid, bus.out_hi, bus.out_lo, bus.proc_flags_out);
        end
    endtask

    task automatic test_arith8();
        vec_t q[$];
        q.push_back({5'd0, 16'h00FF, 16'h0001, 4'b0000, 16'h0000, 4'b1001});
        q.push_back({5'd0, 16'h007F, 16'h0001, 4'b0000, 16'h0080, 4'b0110});
        q.push_back({5'd2, 16'h0010, 16'h0020, 4'b0000, 16'h00F0, 4'b0100});
        q.push_back({5'd3, 16'h0005, 16'h0002, 4'b0000, 16'h0002, 4'b0001});
        q.push_back({5'd4, 16'h0033, 16'h0033, 4'b0000, 16'h0033, 4'b1001});
        q.push_back({5'd1, 16'h0010, 16'h0020, 4'b0011, 16'h0031, 4'b0000});
        q.push_back({5'd0, 16'hAB01, 16'hCD01, 4'b0000, 16'h0002, 4'b0000});
        foreach (q[i]) begin
            drive(q[i]);
            step();
            checks++;
            if ({bus.out_valid, bus.out_hi, bus.out_lo, bus.proc_flags_out} !== {1'b1, q[i].r, q[i].fo}) begin
                errors++;
                $display("FAIL arith8[%0d] op=%0d got v=%b r=%h%h f=%b exp v=1 r=%h f=%b", i, q[i].op,
                         bus.out_valid, bus.out_hi, bus.out_lo, bus.proc_flags_out, q[i].r, q[i].fo);
            end
        end
    endtask

    task automatic test_logic_shift();
        vec_t q[$];
        q.push_back({5'd5, 16'h00F0, 16'h003C, 4'b0011, 16'h0030, 4'b0011});
        q.push_back({5'd6, 16'h0080, 16'h0001, 4'b0000, 16'h0081, 4'b0100});
        q.push_back({5'd7, 16'h005A, 16'h005A, 4'b0001, 16'h0000, 4'b1001});
        q.push_back({5'd13, 16'h00FF, 16'h0000, 4'b0000, 16'h0000, 4'b1000});
        q.push_back({5'd8, 16'h0081, 16'h0001, 4'b0000, 16'h0002, 4'b0001});
        q.push_back({5'd9, 16'h0003, 16'h0001, 4'b0000, 16'h0001, 4'b0001});
        q.push_back({5'd10, 16'h0080, 16'h0003, 4'b0001, 16'h00F0, 4'b0100});
        q.push_back({5'd12, 16'h0001, 16'h0001, 4'b0000, 16'h0080, 4'b0101});
        q.push_back({5'd11, 16'h0080, 16'h0001, 4'b0000, 16'h0001, 4'b0001});
        q.push_back({5'd8, 16'h0040, 16'h0008, 4'b0001, 16'h0040, 4'b0001});
        q.push_back({5'd11, 16'h0000, 16'h0000, 4'b0001, 16'h0000, 4'b1001});
        q.push_back({5'd14, 16'h1234, 16'h775A, 4'b1010, 16'h005A, 4'b1010});
        foreach (q[i]) begin
            drive(q[i]);
            step();
            checks++;
            if ({bus.out_valid, bus.out_hi, bus.out_lo, bus.proc_flags_out} !== {1'b1, q[i].r, q[i].fo}) begin
                errors++;
                $display("FAIL logic_shift[%0d] op=%0d got v=%b r=%h%h f=%b exp v=1 r=%h f=%b", i, q[i].op,
                         bus.out_valid, bus.out_hi, bus.out_lo, bus.proc_flags_out, q[i].r, q[i].fo);
            end
        end
    endtask

    task automatic test_arith16();
        vec_t q[$];
        q.push_back({5'd15, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b1001});
        q.push_back({5'd17, 16'h1000, 16'h77FE, 4'b0000, 16'h0FFE, 4'b0001});
        q.push_back({5'd16, 16'h0000, 16'h0001, 4'b0000, 16'hFFFF, 4'b0100});
        q.push_back({5'd15, 16'h7FFF, 16'h0001, 4'b0000, 16'h8000, 4'b0110});
        q.push_back({5'd18, 16'h1234, 16'hBEEF, 4'b0110, 16'hBEEF, 4'b0110});
        foreach (q[i]) begin
            drive(q[i]);
            step();
            checks++;
            if ({bus.out_valid, bus.out_hi, bus.out_lo, bus.proc_flags_out} !== {1'b1, q[i].r, q[i].fo}) begin
                errors++;
                $display("FAIL arith16[%0d] op=%0d got v=%b r=%h%h f=%b exp v=1 r=%h f=%b", i, q[i].op,
                         bus.out_valid, bus.out_hi, bus.out_lo, bus.proc_flags_out, q[i].r, q[i].fo);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] er [19] = '{16'h0004, 16'h0004, 16'h0002, 16'h0001, 16'h0003, 16'h0001, 16'h0003,
                                 16'h0002, 16'h0006, 16'h0001, 16'h0001, 16'h0006, 16'h0081, 16'h00FC,
                                 16'h0001, 16'h0004, 16'h0002, 16'h0004, 16'h0001};
        logic [3:0] ef [19] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000,
                                4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0101, 4'b0100,
                                4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b1100};
        for (int i = 0; i < 19; i++) begin
            drive({5'(i), 16'h0003, 16'h0001, (i == 18) ? 4'b1100 : 4'b0000, 16'h0, 4'b0});
            step();
            checks++;
            if ({bus.out_valid, bus.out_hi, bus.out_lo, bus.proc_flags_out} !== {1'b1, er[i], ef[i]}) begin
                errors++;
                $display("FAIL b2b[%0d] got v=%b r=%h%h f=%b exp v=1 r=%h f=%b", i,
                         bus.out_valid, bus.out_hi, bus.out_lo, bus.proc_flags_out, er[i], ef[i]);
            end
        end
        bus.in_valid = 1'b0;
        bus.oper = 5'd0;
        {bus.a_in_hi, bus.a_in_lo} = 16'h00FF;
        bus.proc_flags_in = 4'b0011;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({bus.out_valid, bus.out_hi, bus.out_lo, bus.proc_flags_out} !== {1'b0, 16'h0001, 4'b1100}) begin
                errors++;
                $display("FAIL gap_hold[%0d] got v=%b r=%h%h f=%b exp v=0 r=0001 f=1100", i,
                         bus.out_valid, bus.out_hi, bus.out_lo, bus.proc_flags_out);
            end
        end
    endtask

    task automatic test_reserved();
        drive({5'd25, 16'hDEAD, 16'hBEEF, 4'b1011, 16'h0, 4'b0});
        step();
        checks++;
        if ({bus.out_valid, bus.out_hi, bus.out_lo, bus.proc_flags_out} !== {1'b1, 16'h0000, 4'b1011}) begin
            errors++;
            $display("FAIL reserved got v=%b r=%h%h f=%b exp v=1 r=0000 f=1011",
                     bus.out_valid, bus.out_hi, bus.out_lo, bus.proc_flags_out);
        end
    endtask

    task automatic test_reset_inflight();
        drive({5'd0, 16'h0010, 16'h0020, 4'b0000, 16'h0, 4'b0});
        step();
        reset = 1'b0;
        step();
        checks++;
        if ({bus.out_valid, bus.out_hi, bus.out_lo, bus.proc_flags_out} !== 21'h0) begin
            errors++;
            $display("FAIL reset_inflight got v=%b r=%h%h f=%b exp v=0 r=0000 f=0000",
                     bus.out_valid, bus.out_hi, bus.out_lo, bus.proc_flags_out);
        end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_arith8();
        test_logic_shift();
        test_arith16();
        test_back_to_back();
        test_reserved();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/jolt80_alu.md
Name: jolt80_alu

Overview:
- Registered 8/16-bit arithmetic-logic unit for the Jolt80 CPU datapath.
- Operands are 8-bit register values or 16-bit register pairs {hi,lo}. It produces a result pair and an updated 4-bit processor-flags vector.
- Sits between the register file and the writeback/flags register, replacing the combinational ALU with a one-cycle registered stage.

Parameters:
- REG_W, 8, width of one CPU register; pair width = 2*REG_W.
- OP_W, 5, width of oper.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- in_valid  in  1  operands/oper valid this cycle.
- oper  in  5  operation select (pkg_alu::alu_op).
- a_in_hi, a_in_lo  in  8 each  operand A pair.
- b_in_hi, b_in_lo  in  8 each  operand B pair.
- proc_flags_in  in  4  current flags; bit0 C, bit1 V, bit2 N, bit3 Z.
- out_valid  out  1  result registered from the in_valid cycle.
- out_hi, out_lo  out  8 each  result pair.
- proc_flags_out  out  4  updated flags.

Behaviour:
- Timing and control:
  - Latency 1: on a clk edge with reset=1, outputs load f(inputs) and out_valid<=in_valid.
  - With in_valid=0, out_hi/out_lo/proc_flags_out hold their previous values and out_valid<=0.
  - No backpressure.
  - reset=0 at an edge: out_hi=0, out_lo=0, proc_flags_out=0, out_valid=0. Any in-flight operation is discarded; reset wins over in_valid.
- Flag rules:
  - 8-bit ops: Z=(result==0), N=result[7]. For 8-bit ops out_hi=0.
  - 16-bit ops: Z=({hi,lo}==0), N=bit15.
  - Flags not named by an op copy proc_flags_in.
  - C for add = carry out. C for sub = NOT borrow (1 when a>=b unsigned).
  - V = two's-complement signed overflow.
- Ops (oper value: function; flags updated):
  - 0 add8: a_lo+b_lo; ZNCV
  - 1 adc8: a_lo+b_lo+C; ZNCV
  - 2 sub8: a_lo-b_lo; ZNCV
  - 3 sbc8: a_lo-b_lo-!C; ZNCV
  - 4 cmp8: flags as sub8, out_lo=a_lo; ZNCV
  - 5 and8, 6 orr8, 7 xor8: bitwise a_lo op b_lo; ZN (C,V kept)
  - 8 lsl8, 9 lsr8, 10 asr8: shift a_lo by b_lo[2:0]; ZN, C=last bit shifted out. Amount 0: result=a_lo, C kept.
  - 11 rol8, 12 ror8: rotate a_lo by b_lo[2:0]; ZN, C=bit rotated into LSB (rol) / MSB (ror). Amount 0: C kept.
  - 13 not8: ~a_lo; ZN
  - 14 cpy8: out_lo=b_lo; no flags
  - 15 add16: A+B; ZNCV (16-bit)
  - 16 sub16: A-B; ZNCV (16-bit)
  - 17 addsi16: A + sign-extend(b_lo); ZNCV (16-bit)
  - 18 cpy16: {out_hi,out_lo}=B; no flags
  - 19-31 reserved: result 0, flags = proc_flags_in, out_valid still asserted.
- Arithmetic wraps modulo 2^8 / 2^16.

Decomposition:
- pkg_alu: alu_op enum (values above), REG_W/pair width constants.
- pkg_pflags: flag index constants (pflag_c=0, pflag_v=1, pflag_n=2, pflag_z=3) and width 4.
- One sub-module: alu_addsub_core, a combinational 16-bit add/subtract with carry-in, width select (8/16) and C/V outputs. It is shared by add/adc/sub/sbc/cmp/add16/sub16/addsi16.
- Shifts, logic and flag muxing stay in jolt80_alu.

Test Plan:
- Reset: hold reset=0 with in_valid=1, oper=add8 -> outputs 0, flags 0, out_valid 0. Release -> first valid result one cycle later.
- add8 a_lo=0xFF, b_lo=0x01, flags_in=0 -> out_lo=0x00, out_hi=0x00, Z=1 C=1 V=0 N=0. add8 0x7F+0x01 -> 0x80, N=1 V=1 C=0.
- sub8 0x10-0x20 -> 0xF0, C=0 N=1. sbc8 0x05-0x02 with C=0 -> 0x02, C=1. cmp8 0x33,0x33 -> out_lo=0x33, Z=1 C=1.
- lsl8 a=0x81 by 1 -> 0x02, C=1. asr8 0x80 by 3 -> 0xF0, C=0. ror8 0x01 by 1 -> 0x80, C=1. Amount 0 with flags_in C=1 -> C stays 1.
- add16 0xFFFF+0x0001 -> 0x0000, Z=1 C=1. addsi16 A=0x1000, b_lo=0xFE -> 0x0FFE. sub16 0x0000-0x0001 -> 0xFFFF, N=1 C=0.
- Back-to-back valid every cycle over ops 0-18, with an in_valid=0 gap -> outputs held during the gap. Reserved oper 25 -> result 0 with flags_in passed through.
